// File: rtl/audio_ctrl_pkg.sv
// Shared types, field widths and default parameters for the coefficient update scheduler.
package audio_ctrl_pkg;

  localparam int unsigned DEFAULT_FIFO_DEPTH    = 8;
  localparam int unsigned DEFAULT_WINDOW_CYCLES = 64;

  localparam int unsigned SEL_W     = 6;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned ENTRY_W   = 2 + SEL_W + DATA_W;
  localparam int unsigned CNT_OUT_W = 5;

  // Fewer cycles than this left in the window cannot fit a full write sequence.
  localparam int unsigned WIN_MIN_OPEN = 3;

  localparam logic TGT_COEF = 1'b0;
  localparam logic TGT_EQ   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARST  = 2'd1,
    ST_WRITE = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  typedef struct packed {
    logic              target;
    logic              addr_rst;
    logic [SEL_W-1:0]  select;
    logic [DATA_W-1:0] data;
  } req_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read port and occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/coef_update_scheduler.sv
// Queues host coefficient/gain writes and issues them to the FIR and EQ blocks
// only inside the safe window that follows each pipeline-output strobe.
module coef_update_scheduler
  import audio_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
  parameter int unsigned WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 audio_en,
  input  logic                 pipe_in_stb,
  input  logic                 pipe_out_stb,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_target,
  input  logic                 req_addr_rst,
  input  logic [SEL_W-1:0]     req_select,
  input  logic [DATA_W-1:0]    req_data,
  output logic                 coef_wr_en,
  output logic                 eq_wr_en,
  output logic                 coef_addr_rst,
  output logic                 eq_addr_rst,
  output logic [SEL_W-1:0]     wr_select,
  output logic [BYTE_W-1:0]    wr_lsb_data,
  output logic [BYTE_W-1:0]    wr_msb_data,
  output logic [CNT_OUT_W-1:0] pending_cnt,
  output logic                 busy
);

  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WIN_W_RAW = $clog2(WINDOW_CYCLES + 1);
  localparam int unsigned WIN_W     = (WIN_W_RAW < 2) ? 2 : WIN_W_RAW;

  state_e              r_state;
  logic                r_rst_done;
  logic [WIN_W-1:0]    r_win_cnt;
  logic                r_tgt;
  logic                r_coef_wr_en;
  logic                r_eq_wr_en;
  logic                r_coef_addr_rst;
  logic                r_eq_addr_rst;
  logic [SEL_W-1:0]    r_select;
  logic [BYTE_W-1:0]   r_lsb;
  logic [BYTE_W-1:0]   r_msb;

  req_entry_t          w_entry_in;
  req_entry_t          w_head;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic                w_push;
  logic                w_pop;
  logic                w_win_open;

  assign w_entry_in = {req_target, req_addr_rst, req_select, req_data};
  assign req_ready  = r_rst_done && !w_full;
  assign w_push     = req_valid && req_ready;
  assign w_win_open = !audio_en || (r_win_cnt >= WIN_W'(WIN_MIN_OPEN));
  assign w_pop      = (r_state == ST_IDLE) && !w_empty && w_win_open;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_entry_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Keeps req_ready low until the first cycle after reset is released.
  always_ff @(posedge clk) begin
    r_rst_done <= !reset;
  end

  // Safe-write window: loaded by an output strobe, killed by an input strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_cnt <= '0;
    end else if (pipe_in_stb) begin
      r_win_cnt <= '0;
    end else if (pipe_out_stb) begin
      r_win_cnt <= WIN_W'(WINDOW_CYCLES);
    end else if (r_win_cnt != '0) begin
      r_win_cnt <= r_win_cnt - WIN_W'(1);
    end
  end

  // Write sequencer; once out of IDLE a write runs to completion regardless of the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_tgt           <= TGT_COEF;
      r_coef_wr_en    <= 1'b0;
      r_eq_wr_en      <= 1'b0;
      r_coef_addr_rst <= 1'b0;
      r_eq_addr_rst   <= 1'b0;
      r_select        <= '0;
      r_lsb           <= '0;
      r_msb           <= '0;
    end else begin
      r_coef_wr_en    <= 1'b0;
      r_eq_wr_en      <= 1'b0;
      r_coef_addr_rst <= 1'b0;
      r_eq_addr_rst   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_tgt    <= w_head.target;
            r_select <= w_head.select;
            r_lsb    <= w_head.data[BYTE_W-1:0];
            r_msb    <= w_head.data[DATA_W-1:BYTE_W];
            r_state  <= w_head.addr_rst ? ST_ARST : ST_WRITE;
          end
        end
        ST_ARST: begin
          r_coef_addr_rst <= (r_tgt == TGT_COEF);
          r_eq_addr_rst   <= (r_tgt == TGT_EQ);
          r_state         <= ST_WRITE;
        end
        ST_WRITE: begin
          r_coef_wr_en <= (r_tgt == TGT_COEF);
          r_eq_wr_en   <= (r_tgt == TGT_EQ);
          r_state      <= ST_GAP;
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign coef_wr_en    = r_coef_wr_en;
  assign eq_wr_en      = r_eq_wr_en;
  assign coef_addr_rst = r_coef_addr_rst;
  assign eq_addr_rst   = r_eq_addr_rst;
  assign wr_select     = r_select;
  assign wr_lsb_data   = r_lsb;
  assign wr_msb_data   = r_msb;
  assign pending_cnt   = CNT_OUT_W'(w_count);
  assign busy          = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_coef_update_scheduler.sv
// Self-checking bench for coef_update_scheduler: vector table, directed corner sequences
// and randomized traffic against a transaction-level schedule model.
`timescale 1ns/1ps
module tb_coef_update_scheduler;
  import audio_ctrl_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIN   = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        audio_en, pipe_in_stb, pipe_out_stb;
  logic        req_valid, req_ready, req_target, req_addr_rst;
  logic [5:0]  req_select;
  logic [15:0] req_data;
  logic        coef_wr_en, eq_wr_en, coef_addr_rst, eq_addr_rst;
  logic [5:0]  wr_select;
  logic [7:0]  wr_lsb_data, wr_msb_data;
  logic [4:0]  pending_cnt;
  logic        busy;

  always #5 clk = ~clk;

  coef_update_scheduler #(.FIFO_DEPTH(DEPTH), .WINDOW_CYCLES(WIN)) dut (
    .clk(clk), .reset(reset), .audio_en(audio_en), .pipe_in_stb(pipe_in_stb),
    .pipe_out_stb(pipe_out_stb), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .req_addr_rst(req_addr_rst), .req_select(req_select),
    .req_data(req_data), .coef_wr_en(coef_wr_en), .eq_wr_en(eq_wr_en),
    .coef_addr_rst(coef_addr_rst), .eq_addr_rst(eq_addr_rst), .wr_select(wr_select),
    .wr_lsb_data(wr_lsb_data), .wr_msb_data(wr_msb_data), .pending_cnt(pending_cnt),
    .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Schedule model: a queue of requests plus the absolute cycles at which each write's strobes appear.
  req_entry_t  m_q[$];
  int          m_win      = 0;
  bit          m_rst_done = 0;
  int          m_cyc      = 0;
  int          m_free     = 0;
  int          m_t_arst   = -1;
  int          m_t_wr     = -1;
  bit          m_tgt      = 0;
  logic [5:0]  m_sel      = '0;
  logic [15:0] m_data     = '0;

  typedef struct {
    bit        v, tgt, arst;
    bit [5:0]  sel;
    bit [15:0] data;
    bit [3:0]  stb;   // {coef_wr, eq_wr, coef_arst, eq_arst}
    int        pend;
    bit        chk;
    bit [5:0]  esel;
    bit [15:0] edata;
  } vec_t;

  vec_t tv[20];

  function automatic vec_t mk(bit v, bit tgt, bit arst, bit [5:0] sel, bit [15:0] data,
                              bit [3:0] stb, int pend, bit chk, bit [5:0] esel, bit [15:0] edata);
    vec_t r;
    r.v = v; r.tgt = tgt; r.arst = arst; r.sel = sel; r.data = data;
    r.stb = stb; r.pend = pend; r.chk = chk; r.esel = esel; r.edata = edata;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at model cycle %0d: got %0h, expected %0h", name, m_cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    req_entry_t e;
    bit rdy, open;
    if (reset) begin
      m_q.delete();
      m_win = 0; m_rst_done = 0; m_free = m_cyc + 1;
      m_t_arst = -1; m_t_wr = -1; m_tgt = 0; m_sel = '0; m_data = '0;
    end else begin
      rdy  = m_rst_done && (m_q.size() < DEPTH);
      open = !audio_en || (m_win >= 3);
      if (m_cyc >= m_free && m_q.size() > 0 && open) begin
        e = m_q.pop_front();
        m_tgt = e.target; m_sel = e.select; m_data = e.data;
        if (e.addr_rst) begin
          m_t_arst = m_cyc + 2; m_t_wr = m_cyc + 3; m_free = m_cyc + 4;
        end else begin
          m_t_arst = -1; m_t_wr = m_cyc + 2; m_free = m_cyc + 3;
        end
      end
      if (req_valid && rdy) begin
        e.target = req_target; e.addr_rst = req_addr_rst;
        e.select = req_select; e.data = req_data;
        m_q.push_back(e);
      end
      if (pipe_in_stb) m_win = 0;
      else if (pipe_out_stb) m_win = WIN;
      else if (m_win > 0) m_win--;
      m_rst_done = 1;
    end
    m_cyc++;
  endtask

  task automatic check_model();
    chk("coef_wr_en", 32'(coef_wr_en), 32'(m_cyc == m_t_wr && m_tgt == TGT_COEF));
    chk("eq_wr_en", 32'(eq_wr_en), 32'(m_cyc == m_t_wr && m_tgt == TGT_EQ));
    chk("coef_addr_rst", 32'(coef_addr_rst), 32'(m_cyc == m_t_arst && m_tgt == TGT_COEF));
    chk("eq_addr_rst", 32'(eq_addr_rst), 32'(m_cyc == m_t_arst && m_tgt == TGT_EQ));
    chk("wr_select", 32'(wr_select), 32'(m_sel));
    chk("wr_data", 32'({wr_msb_data, wr_lsb_data}), 32'(m_data));
    chk("pending_cnt", 32'(pending_cnt), 32'(m_q.size()));
    chk("req_ready", 32'(req_ready), 32'(m_rst_done && m_q.size() < DEPTH));
    chk("busy", 32'(busy), 32'(m_cyc < m_free || m_q.size() > 0));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive_idle();
    req_valid = 1'b0; pipe_in_stb = 1'b0; pipe_out_stb = 1'b0;
  endtask

  task automatic push(input bit tgt, input bit arst, input bit [5:0] sel, input bit [15:0] data);
    req_valid = 1'b1; req_target = tgt; req_addr_rst = arst; req_select = sel; req_data = data;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    int nwr;
    tv[0]  = mk(1, 0, 0, 6'd1,  16'h1111, 4'b0000, 1, 0, 6'd0,  16'h0000);
    tv[1]  = mk(1, 0, 0, 6'd2,  16'h2222, 4'b0000, 1, 0, 6'd0,  16'h0000);
    tv[2]  = mk(1, 0, 0, 6'd3,  16'h3333, 4'b1000, 2, 1, 6'd1,  16'h1111);
    tv[3]  = mk(0, 0, 0, 6'd0,  16'h0000, 4'b0000, 2, 1, 6'd1,  16'h1111);
    tv[4]  = mk(0, 0, 0, 6'd0,  16'h0000, 4'b0000, 1, 0, 6'd0,  16'h0000);
    tv[5]  = mk(0, 0, 0, 6'd0,  16'h0000, 4'b1000, 1, 1, 6'd2,  16'h2222);
    tv[6]  = mk(0, 0, 0, 6'd0,  16'h0000, 4'b0000, 1, 0, 6'd0,  16'h0000);
    tv[7]  = mk(0, 0, 0, 6'd0,  16'h0000, 4'b0000, 0, 0, 6'd0,  16'h0000);
    tv[8]  = mk(0, 0, 0, 6'd0,  16'h0000, 4'b1000, 0, 1, 6'd3,  16'h3333);
    tv[9]  = mk(0, 0, 0, 6'd0,  16'h0000, 4'b0000, 0, 1, 6'd3,  16'h3333);
    tv[10] = mk(1, 1, 1, 6'd5,  16'hABCD, 4'b0000, 1, 0, 6'd0,  16'h0000);
    tv[11] = mk(0, 0, 0, 6'd0,  16'h0000, 4'b0000, 0, 0, 6'd0,  16'h0000);
    tv[12] = mk(0, 0, 0, 6'd0,  16'h0000, 4'b0001, 0, 1, 6'd5,  16'hABCD);
    tv[13] = mk(0, 0, 0, 6'd0,  16'h0000, 4'b0100, 0, 1, 6'd5,  16'hABCD);
    tv[14] = mk(0, 0, 0, 6'd0,  16'h0000, 4'b0000, 0, 0, 6'd0,  16'h0000);
    tv[15] = mk(1, 0, 1, 6'h3F, 16'h00FF, 4'b0000, 1, 0, 6'd0,  16'h0000);
    tv[16] = mk(0, 0, 0, 6'd0,  16'h0000, 4'b0000, 0, 0, 6'd0,  16'h0000);
    tv[17] = mk(0, 0, 0, 6'd0,  16'h0000, 4'b0010, 0, 1, 6'h3F, 16'h00FF);
    tv[18] = mk(0, 0, 0, 6'd0,  16'h0000, 4'b1000, 0, 1, 6'h3F, 16'h00FF);
    tv[19] = mk(0, 0, 0, 6'd0,  16'h0000, 4'b0000, 0, 0, 6'd0,  16'h0000);

    reset = 1'b1; audio_en = 1'b0; drive_idle();
    req_target = 1'b0; req_addr_rst = 1'b0; req_select = '0; req_data = '0;

    // Reset state
    repeat (3) step();
    chk("rst_strobes", 32'({coef_wr_en, eq_wr_en, coef_addr_rst, eq_addr_rst}), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_pending", 32'(pending_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Vector table, audio_en low: back-to-back writes and address-reset writes
    for (int i = 0; i < 20; i++) begin
      req_valid = tv[i].v; req_target = tv[i].tgt; req_addr_rst = tv[i].arst;
      req_select = tv[i].sel; req_data = tv[i].data;
      step();
      chk($sformatf("tv%0d_strobes", i),
          32'({coef_wr_en, eq_wr_en, coef_addr_rst, eq_addr_rst}), 32'(tv[i].stb));
      chk($sformatf("tv%0d_pending", i), 32'(pending_cnt), 32'(tv[i].pend));
      if (tv[i].chk) begin
        chk($sformatf("tv%0d_select", i), 32'(wr_select), 32'(tv[i].esel));
        chk($sformatf("tv%0d_data", i), 32'({wr_msb_data, wr_lsb_data}), 32'(tv[i].edata));
      end
    end
    drive_idle();

    // Closed window holds an EQ write until pipe_out_stb, then 2-cycle latency
    audio_en = 1'b1;
    push(1'b1, 1'b0, 6'd9, 16'h5A5A);
    step();
    drive_idle();
    nwr = 0;
    repeat (500) begin
      step();
      if (coef_wr_en || eq_wr_en || coef_addr_rst || eq_addr_rst) nwr++;
    end
    chk("closed_no_strobe", 32'(nwr), 32'd0);
    pipe_out_stb = 1'b1;
    step();
    pipe_out_stb = 1'b0;
    step();
    chk("eq_wr_early", 32'(eq_wr_en), 32'd0);
    step();
    chk("eq_wr_after_open", 32'(eq_wr_en), 32'd1);
    chk("eq_wr_select", 32'(wr_select), 32'd9);
    repeat (2) step();

    // Fill the FIFO with the window closed, then drain it in one window
    pipe_in_stb = 1'b1;
    step();
    pipe_in_stb = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push(1'($urandom), 1'b0, 6'(i + 10), 16'(i * 4369 + 7));
      step();
    end
    drive_idle();
    chk("full_ready", 32'(req_ready), 32'd0);
    chk("full_pending", 32'(pending_cnt), 32'd8);
    pipe_out_stb = 1'b1;
    step();
    pipe_out_stb = 1'b0;
    nwr = 0;
    repeat (30) begin
      step();
      if (coef_wr_en || eq_wr_en) nwr++;
    end
    chk("drain_count", 32'(nwr), 32'd8);
    chk("drain_pending", 32'(pending_cnt), 32'd0);

    // Simultaneous pipe_in/pipe_out keeps the window closed
    pipe_in_stb = 1'b1;
    step();
    pipe_in_stb = 1'b0;
    push(1'b0, 1'b0, 6'd33, 16'hC0DE);
    step();
    drive_idle();
    pipe_in_stb = 1'b1; pipe_out_stb = 1'b1;
    step();
    drive_idle();
    nwr = 0;
    repeat (20) begin
      step();
      if (coef_wr_en || eq_wr_en || coef_addr_rst || eq_addr_rst) nwr++;
    end
    chk("collide_no_strobe", 32'(nwr), 32'd0);
    chk("collide_pending", 32'(pending_cnt), 32'd1);
    audio_en = 1'b0;
    repeat (5) step();

    // Reset during ARST aborts the write
    push(1'b0, 1'b1, 6'd7, 16'h7777);
    step();
    drive_idle();
    step();
    chk("arst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    chk("abort_strobes", 32'({coef_wr_en, eq_wr_en, coef_addr_rst, eq_addr_rst}), 32'd0);
    step();
    reset = 1'b0;
    nwr = 0;
    repeat (10) begin
      step();
      if (coef_wr_en || eq_wr_en || coef_addr_rst || eq_addr_rst) nwr++;
    end
    chk("abort_no_strobe", 32'(nwr), 32'd0);
    chk("abort_pending", 32'(pending_cnt), 32'd0);

    // Randomized traffic against the schedule model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(49) == 0) audio_en = ~audio_en;
      pipe_out_stb = ($urandom_range(39) == 0);
      pipe_in_stb  = ($urandom_range(59) == 0);
      req_valid    = $urandom_range(1);
      req_target   = $urandom_range(1);
      req_addr_rst = $urandom_range(1);
      req_select   = 6'($urandom);
      req_data     = 16'($urandom);
      reset        = ($urandom_range(699) == 0);
      step();
    end
    reset = 1'b0;
    drive_idle();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/coef_update_scheduler.md
COEF_UPDATE_SCHEDULER -- requirements
Module: coef_update_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, is the number of queued write requests (power of two, 2..16).
REQ-002 Parameter WINDOW_CYCLES, default 64, is the safe-write window length in clk cycles after each pipeline-output strobe.
REQ-003 One clock and one synchronous active-high reset: clk  input  1  system clock; reset  input  1  synchronous, active-high.
REQ-004 audio_en  input  1  audio pipeline running; when low, writes are always permitted.
REQ-005 pipe_in_stb  input  1  sample entering the FIR pipeline; closes any open window.
REQ-006 pipe_out_stb  input  1  equalizer output valid; opens a window.
REQ-007 req_valid / req_ready  input / output  1 / 1  host write handshake; a transfer occurs when both are high.
REQ-008 req_target  input  1  0 = FIR coefficient, 1 = EQ gain.
REQ-009 req_addr_rst  input  1  pulse the target's address reset before this write.
REQ-010 req_select  input  6  filter or EQ band select.
REQ-011 req_data  input  16  coefficient or gain value.
REQ-012 coef_wr_en, eq_wr_en, coef_addr_rst, eq_addr_rst  output  1 each  single-cycle strobes to FIR_Filters and EqualizerGains.
REQ-013 wr_select  output  6; wr_lsb_data, wr_msb_data  output  8 each; these are held stable from the first strobe of a write until the next write begins.
REQ-014 pending_cnt  output  5  FIFO occupancy; busy  output  1  FSM not IDLE or FIFO not empty.

Function
REQ-015 Requests are pushed into a FIFO of 24-bit entries {target, addr_rst, select, data}; req_ready SHALL equal not-full.
REQ-016 A push and a pop in the same cycle SHALL both occur and leave pending_cnt unchanged.
REQ-017 Window counter: pipe_out_stb loads WINDOW_CYCLES; the counter otherwise decrements to 0 and holds; pipe_in_stb forces it to 0.
REQ-018 If pipe_in_stb and pipe_out_stb occur in the same cycle, pipe_in_stb wins and the counter becomes 0.
REQ-019 The window is open when audio_en = 0 or the counter is >= 3.
REQ-020 The FSM has states IDLE, ARST, WRITE and GAP.
REQ-021 IDLE: when the FIFO is non-empty and the window is open, pop the head entry and latch its fields into output registers; go to ARST if addr_rst = 1, otherwise go to WRITE.
REQ-022 ARST: assert the target's addr_rst strobe for exactly 1 cycle, then go to WRITE.
REQ-023 WRITE: assert the target's wr_en strobe for exactly 1 cycle, then go to GAP.
REQ-024 GAP: assert no strobes for 1 cycle, then go to IDLE.
REQ-025 Latency from an open window with a non-empty FIFO to wr_en is 2 cycles (ARST skipped) or 3 cycles (ARST taken).
REQ-026 A write that has left IDLE SHALL complete, even if the window closes or audio_en changes.
REQ-027 Strobes for the non-selected target SHALL stay 0; at most one strobe is high in any cycle.
REQ-028 Writes are issued in strict FIFO order; no request is dropped or duplicated.

Reset
REQ-029 While reset is high, all strobes are 0, wr_select/wr_lsb_data/wr_msb_data are 0, the FIFO is flushed (pending_cnt = 0), the window counter is 0, the FSM is IDLE, busy = 0 and req_ready = 0.
REQ-030 req_ready = 1 one cycle after reset deasserts.
REQ-031 Reset asserted mid-write aborts the write with no further strobes.

Structure
REQ-032 Package audio_ctrl_pkg SHALL hold the state enum, the target encoding (TGT_COEF = 0, TGT_EQ = 1), the entry field widths and the default parameters.
REQ-033 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by WIDTH and DEPTH.

Verification
REQ-034 Scenario, audio_en = 0: push 3 coef writes without addr_rst -> coef_wr_en at cycles 2, 5 and 8 after the first push is visible; data matches in order.
REQ-035 Scenario, audio_en = 1, no pipe_out_stb: push 1 EQ write -> no strobe for 500 cycles; then pipe_out_stb -> eq_wr_en 2 cycles later.
REQ-036 Scenario, addr_rst = 1 with target = coef -> coef_addr_rst pulse, then coef_wr_en on the next cycle; eq strobes stay 0.
REQ-037 Scenario, fill 8 entries with audio_en = 1 and the window closed -> req_ready = 0 and pending_cnt = 8; a pipe_out_stb drains exactly one entry per 3 cycles until the counter drops below 3.
REQ-038 Scenario, pipe_in_stb and pipe_out_stb in the same cycle -> the window stays closed and no write is issued.
REQ-039 Scenario, reset asserted in the cycle of ARST -> no wr_en follows and pending_cnt = 0 after reset.
